// File: rtl/coin_acceptor.sv
// Coin sensor front end: two synchronised/debounced coin channels feeding a small
// coin FIFO whose head is replayed to the vending FSM as a 2-bit cash_in code.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          coin1_raw,
  input  logic                          coin2_raw,
  input  logic                          accept_en,
  input  logic                          hold,
  output logic [1:0]                    cash_in,
  output logic                          coin_reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW:0]   LVL_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    CASH_IDLE = 2'b00,
    CASH_ONE  = 2'b01,
    CASH_TWO  = 2'b10
  } cash_e;

  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    rise;

  logic          pend_q, pend_d;
  logic          ev_valid;
  cash_e         ev_code;

  cash_e         mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   level_q, level_d;
  logic          pop, push, reject, full_after_pop;

  cash_e         stage_q, stage_d;
  cash_e         cash_q, cash_d;
  logic          reject_q;

  assign raw = {coin2_raw, coin1_raw};

  // NOTE: always_comb gives every output a default first so no path leaves a
  // signal unassigned, which is what would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      deb_d[i] = deb_q[i];
      rise[i]  = 1'b0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
          rise[i]  = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Coin1 wins a tie; a coin2 event that loses is parked in pend_q for one cycle.
  always_comb begin
    ev_valid = 1'b0;
    ev_code  = CASH_IDLE;
    pend_d   = pend_q;
    if (rise[0]) begin
      ev_valid = 1'b1;
      ev_code  = CASH_ONE;
      pend_d   = pend_q | rise[1];
    end else if (pend_q) begin
      ev_valid = 1'b1;
      ev_code  = CASH_TWO;
      pend_d   = rise[1];
    end else if (rise[1]) begin
      ev_valid = 1'b1;
      ev_code  = CASH_TWO;
    end
  end

  always_comb begin
    pop            = (level_q != '0) && !hold;
    full_after_pop = (level_q == LVL_FULL) && !pop;
    push           = ev_valid && accept_en && !full_after_pop;
    reject         = ev_valid && (!accept_en || full_after_pop);
    level_d        = level_q + (PW + 1)'(push) - (PW + 1)'(pop);
    // The stage keeps a popped code through a stall so hold never drops a coin.
    stage_d        = hold ? stage_q : (pop ? mem_q[rd_ptr_q] : CASH_IDLE);
    cash_d         = hold ? CASH_IDLE : stage_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      stage_q  <= CASH_IDLE;
      cash_q   <= CASH_IDLE;
      reject_q <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      pend_q   <= pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      stage_q  <= stage_d;
      cash_q   <= cash_d;
      reject_q <= reject;
    end
  end

  // NOTE: the storage array is not reset; the pointers and level define which
  // entries are valid, so clearing those empties the queue.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ev_code;
  end

  assign cash_in     = cash_q;
  assign coin_reject = reject_q;
  assign fifo_level  = level_q;

endmodule
